// File: rtl/ecc_pkg.sv
// Shared types and helpers for the ECC nonce sampler.
// State encoding and width helper used by the sampler and its tests.
package ecc_pkg;

  localparam int WID_D = 256;

  typedef enum logic [2:0] {
    IDLE,
    MASK,
    SAMPLE,
    CHECK,
    DONE
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/lv_msbmask.sv
// Ones-mask covering every bit up to the highest set bit of the input.
// Zero input yields an all-zero mask.
module lv_msbmask #(
  parameter int WID = 256
) (
  input  logic [WID-1:0] value,
  output logic [WID-1:0] mask
);

  for (genvar i = 0; i < WID; i++) begin : g_bit
    assign mask[i] = |value[WID-1:i];
  end

endmodule

// File: rtl/ecc_nonce_sampler.sv
// Rejection sampler producing a nonce k with 0 < k < n from a random word.
// Candidates are masked to the bit length of n; attempts are bounded.
module ecc_nonce_sampler
  import ecc_pkg::*;
#(
  parameter int WID    = WID_D,
  parameter int MAXTRY = 16,
  parameter int STRIDE = 8,
  parameter int TW     = clog2(MAXTRY + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [WID-1:0] randvl,
  input  logic [WID-1:0] ordn,
  input  logic           req_vld,
  output logic           req_rdy,
  output logic           out_vld,
  input  logic           out_rdy,
  output logic [WID-1:0] nonce,
  output logic           err,
  output logic [TW-1:0]  ntries
);

  localparam int GW = clog2(STRIDE + 1);

  state_t         state, state_n;
  logic [WID-1:0] order_r, order_n;
  logic [WID-1:0] mask_r, mask_n;
  logic [WID-1:0] mask_w;
  logic [WID-1:0] cand, cand_n;
  logic [WID-1:0] nonce_n;
  logic [TW-1:0]  tries, tries_n;
  logic [TW-1:0]  ntries_n;
  logic [GW-1:0]  gapcnt, gap_n;
  logic           err_n;

  lv_msbmask #(.WID(WID)) u_mask (
    .value (order_r),
    .mask  (mask_w)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      order_r <= '0;
      mask_r  <= '0;
      cand    <= '0;
      tries   <= '0;
      gapcnt  <= '0;
      nonce   <= '0;
      err     <= 1'b0;
      ntries  <= '0;
    end else begin
      state   <= state_n;
      order_r <= order_n;
      mask_r  <= mask_n;
      cand    <= cand_n;
      tries   <= tries_n;
      gapcnt  <= gap_n;
      nonce   <= nonce_n;
      err     <= err_n;
      ntries  <= ntries_n;
    end
  end

  always_comb begin
    state_n  = state;
    order_n  = order_r;
    mask_n   = mask_r;
    cand_n   = cand;
    tries_n  = tries;
    gap_n    = gapcnt;
    nonce_n  = nonce;
    err_n    = err;
    ntries_n = ntries;
    req_rdy  = 1'b0;
    out_vld  = 1'b0;
    unique case (state)
      IDLE: begin
        req_rdy = 1'b1;
        if (req_vld) begin
          order_n = ordn;
          tries_n = '0;
          state_n = MASK;
        end
      end
      MASK: begin
        mask_n = mask_w;
        // n < 2 leaves no legal nonce at all
        if (order_r[WID-1:1] == '0) begin
          nonce_n  = '0;
          err_n    = 1'b1;
          ntries_n = '0;
          state_n  = DONE;
        end else begin
          gap_n   = '0;
          state_n = SAMPLE;
        end
      end
      SAMPLE: begin
        if (gapcnt == GW'(STRIDE - 1)) begin
          cand_n  = randvl & mask_r;
          tries_n = tries + TW'(1);
          state_n = CHECK;
        end else begin
          gap_n = gapcnt + GW'(1);
        end
      end
      CHECK: begin
        if (cand != '0 && cand < order_r) begin
          nonce_n  = cand;
          err_n    = 1'b0;
          ntries_n = tries;
          state_n  = DONE;
        end else if (tries == TW'(MAXTRY)) begin
          nonce_n  = '0;
          err_n    = 1'b1;
          ntries_n = tries;
          state_n  = DONE;
        end else begin
          gap_n   = '0;
          state_n = SAMPLE;
        end
      end
      DONE: begin
        out_vld = 1'b1;
        if (out_rdy) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/ecc_nonce_sampler.md
Name: ecc_nonce_sampler

Overview:
Consumer of the 256-bit pseudo-random word from the ECC core's free-running random generator. On request, draws random words and applies rejection sampling to produce a scalar nonce k with 0 < k < n, where n is the curve order. The result feeds the scalar-multiply front end. Candidates are masked to the bit length of n to raise the acceptance rate. A bounded retry count guarantees termination.

Parameters:
WID, 256, datapath width of random word, order and nonce
MAXTRY, 16, maximum sampling attempts before error (>=1)
STRIDE, 8, clocks between successive samples so the random source advances (>=1)
TW, clog2(MAXTRY+1), width of attempt counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
randvl  in  WID  random word from generator, new value every clock
ordn  in  WID  curve order n, sampled only on request acceptance
req_vld  in  1  nonce request
req_rdy  out  1  block idle, request accepted when req_vld & req_rdy
out_vld  out  1  result valid, held until out_rdy
out_rdy  in  1  downstream accepts result
nonce  out  WID  sampled k, 0 when err
err  out  1  1 = order invalid (n<2) or MAXTRY exhausted
ntries  out  TW  attempts consumed for this result

Behaviour:
- Reset (rst=0, async): state IDLE; order_r, mask_r, cand, nonce=0; err=0; ntries=0; out_vld=0; req_rdy=1 after release.
- IDLE: req_rdy=1. On req_vld: order_r<=ordn; tries<=0; go to MASK. req_rdy=0 in every other state; req_vld there is ignored.
- MASK: mask_r <= ones over bits [msb(order_r):0].
  - If order_r<2: go to DONE with err=1, nonce=0, ntries=0.
  - Else: gapcnt<=0, go to SAMPLE.
- SAMPLE: if gapcnt==STRIDE-1: cand<=randvl & mask_r, tries<=tries+1, go to CHECK. Otherwise gapcnt++.
- CHECK: unsigned full-width compare.
  - If cand!=0 && cand<order_r: go to DONE with nonce=cand, err=0.
  - Else if tries==MAXTRY: go to DONE with nonce=0, err=1.
  - Else: gapcnt<=0, go to SAMPLE.
- DONE: out_vld=1. nonce, err and ntries (=tries) are registered and stable while waiting. On out_rdy: go to IDLE, out_vld=0 next cycle. No new request is accepted in the same cycle.
- Latency, acceptance at cycle T, STRIDE=S: first out_vld at T+3+S. Each rejected attempt adds S+1 cycles.
- ordn changes after acceptance have no effect. randvl is sampled only in the SAMPLE exit cycle.
- Boundaries:
  - cand==order_r is rejected.
  - cand==0 is rejected.
  - order=2^(WID-1)+x gives an all-ones mask.
  - A counter overflow is impossible because TW covers MAXTRY.
- Reset asserted mid-operation: immediate return to IDLE, any pending result discarded, out_vld drops asynchronously.

Decomposition:
- Shared package ecc_pkg: WID default, state encoding (IDLE, MASK, SAMPLE, CHECK, DONE), clog2 function.
- One natural sub-module: lv_msbmask. It is combinational, WID-bit input, and outputs the ones-mask up to the highest set bit; the result is registered in MASK.

Test Plan:
- STRIDE=1, ordn=7, randvl held 5, req at T -> out_vld at T+4, nonce=5, ntries=1, err=0.
- STRIDE=1, ordn=7, randvl 0 / 7 / 3 on successive sample cycles -> nonce=3, ntries=3, out_vld at T+8. Also randvl=0xFF..FD with ordn=7 -> masked cand=5 accepted.
- MAXTRY=4, ordn=7, randvl held 0 -> err=1, nonce=0, ntries=4. ordn=1 -> err=1, ntries=0, out_vld at T+2.
- Back-pressure: out_rdy low 10 cycles -> out_vld, nonce, err stable. req_vld asserted throughout -> not accepted until one cycle after out_rdy handshake.
- ordn=2^255+1 with real generator attached, 1000 requests -> every nonce in [1, n-1], err=0, ntries<=MAXTRY.
- rst pulsed low during SAMPLE -> out_vld=0, req_rdy=1 after release. Next request completes normally with ntries counting from 1.
